// File: rtl/op_rr_encoder.sv
// Round-robin opcode encoder: picks one of 16 requesters fairly, offers it
// downstream over a valid/ready handshake and counts accepted opcodes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing offered; op_valid=0, op_sel holds its last value
// OFFER | op_sel/grant hold a stable offer until op_ready accepts it
module op_rr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        op_ready,
  output logic        op_valid,
  output logic [3:0]  op_sel,
  output logic [15:0] grant,
  output logic [7:0]  issue_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_sel_q, op_sel_d;
  logic [15:0] grant_q, grant_d;
  logic [7:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  last_ptr_q, last_ptr_d;

  logic        handshake;
  logic [3:0]  search_base;
  logic [3:0]  cand;
  logic [3:0]  winner;
  logic        winner_found;

  // A handshake this cycle moves the pointer, so the next search already
  // starts past the opcode being accepted; this is what removes the bubble.
  always_comb begin
    handshake   = (state_q == OFFER) && op_ready;
    search_base = handshake ? op_sel_q : last_ptr_q;
  end

  // Scan from the farthest position back to the nearest; the last hit wins,
  // which is the first set bit in ascending order after search_base.
  always_comb begin
    cand         = 4'h0;
    winner       = 4'h0;
    winner_found = 1'b0;
    for (int k = 16; k >= 1; k--) begin
      cand = search_base + k[3:0];
      if (req[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_sel_q    <= 4'h0;
      grant_q     <= 16'h0000;
      issue_cnt_q <= 8'h00;
      last_ptr_q  <= 4'hF;
    end else begin
      state_q     <= state_d;
      op_sel_q    <= op_sel_d;
      grant_q     <= grant_d;
      issue_cnt_q <= issue_cnt_d;
      last_ptr_q  <= last_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_sel_d    = op_sel_q;
    grant_d     = grant_q;
    issue_cnt_d = issue_cnt_q;
    last_ptr_d  = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (winner_found) begin
          state_d  = OFFER;
          op_sel_d = winner;
          grant_d  = 16'h0001 << winner;
        end
      end
      OFFER: begin
        if (op_ready) begin
          issue_cnt_d = issue_cnt_q + 8'd1;
          last_ptr_d  = op_sel_q;
          if (winner_found) begin
            op_sel_d = winner;
            grant_d  = 16'h0001 << winner;
          end else begin
            state_d = IDLE;
            grant_d = 16'h0000;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 16'h0000;
      end
    endcase
  end

  always_comb begin
    op_valid  = (state_q == OFFER);
    op_sel    = op_sel_q;
    grant     = grant_q;
    issue_cnt = issue_cnt_q;
  end

endmodule

// File: tb/tb_op_rr_encoder.sv
// Bench for op_rr_encoder: a reference model queues the expected outputs of
// every cycle; an independent monitor compares them after each clock edge.
module tb_op_rr_encoder;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        op_ready;
  logic        op_valid;
  logic [3:0]  op_sel;
  logic [15:0] grant;
  logic [7:0]  issue_cnt;

  op_rr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_ready  (op_ready),
    .op_valid  (op_valid),
    .op_sel    (op_sel),
    .grant     (grant),
    .issue_cnt (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  s;
    logic [15:0] g;
    logic [7:0]  c;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an offer (or none), the last accepted opcode, the count
  bit m_valid = 1'b0;
  int m_sel   = 0;
  int m_ptr   = 15;
  int m_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input logic [15:0] r, input logic rd, input logic rs);
    exp_t e;
    int   idx;
    if (rs) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_cnt   = 0;
      m_ptr   = 15;
    end else begin
      if (m_valid && rd) begin
        m_cnt   = (m_cnt + 1) % 256;
        m_ptr   = m_sel;
        m_valid = 1'b0;
      end
      if (!m_valid && r != 16'h0000) begin
        for (int k = 1; k <= 16; k++) begin
          idx = (m_ptr + k) % 16;
          if (r[idx]) begin
            m_sel   = idx;
            m_valid = 1'b1;
            break;
          end
        end
      end
    end
    e.v = m_valid;
    e.s = m_sel[3:0];
    e.g = m_valid ? (16'h0001 << m_sel) : 16'h0000;
    e.c = m_cnt[7:0];
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, queue the expectation, return after the
  // monitor has compared the post-edge outputs.
  task automatic cycle(input logic [15:0] r, input logic rd, input logic rs);
    @(negedge clk);
    req      = r;
    op_ready = rd;
    rst      = rs;
    model_step(r, rd, rs);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_op_valid",  {31'd0, op_valid}, {31'd0, e.v});
      check("sb_op_sel",    {28'd0, op_sel},   {28'd0, e.s});
      check("sb_grant",     {16'd0, grant},    {16'd0, e.g});
      check("sb_issue_cnt", {24'd0, issue_cnt},{24'd0, e.c});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  seq_exp[5];
    logic [7:0]  cnt0;
    logic [15:0] r;
    req      = 16'h0000;
    op_ready = 1'b0;
    rst      = 1'b1;

    // Reset state
    cycle(16'h0000, 1'b0, 1'b1);
    cycle(16'hFFFF, 1'b1, 1'b1);
    check("rst_valid", {31'd0, op_valid}, 32'd0);
    check("rst_sel",   {28'd0, op_sel},   32'd0);
    check("rst_grant", {16'd0, grant},    32'd0);
    check("rst_cnt",   {24'd0, issue_cnt},32'd0);

    // Single request, one-cycle latency, then handshake
    cycle(16'h0001, 1'b1, 1'b0);
    check("first_valid", {31'd0, op_valid}, 32'd1);
    check("first_sel",   {28'd0, op_sel},   32'd0);
    check("first_grant", {16'd0, grant},    32'h0001);
    check("first_cnt",   {24'd0, issue_cnt},32'd0);
    cycle(16'h0000, 1'b1, 1'b0);
    check("first_cnt_after", {24'd0, issue_cnt}, 32'd1);
    check("first_idle",      {31'd0, op_valid},  32'd0);

    // Back-to-back round robin over 8421
    cycle(16'h0000, 1'b0, 1'b1);
    seq_exp[0] = 4'h0; seq_exp[1] = 4'h5; seq_exp[2] = 4'hA;
    seq_exp[3] = 4'hF; seq_exp[4] = 4'h0;
    for (int i = 0; i < 5; i++) begin
      cycle(16'h8421, 1'b1, 1'b0);
      check("rr_valid", {31'd0, op_valid}, 32'd1);
      check("rr_sel",   {28'd0, op_sel},   {28'd0, seq_exp[i]});
    end
    cycle(16'h0000, 1'b1, 1'b0);
    check("rr_cnt", {24'd0, issue_cnt}, 32'd5);

    // Backpressure with the request withdrawn
    cnt0 = 8'd5;
    cycle(16'h0008, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle((i == 0) ? 16'h0008 : 16'h0000, 1'b0, 1'b0);
      check("bp_valid", {31'd0, op_valid}, 32'd1);
      check("bp_sel",   {28'd0, op_sel},   32'd3);
      check("bp_grant", {16'd0, grant},    32'h0008);
      check("bp_cnt",   {24'd0, issue_cnt},{24'd0, cnt0});
    end
    cycle(16'h0000, 1'b1, 1'b0);
    check("bp_cnt_acc", {24'd0, issue_cnt}, {24'd0, cnt0 + 8'd1});
    check("bp_idle",    {31'd0, op_valid},  32'd0);

    // Pointer wrap: after accepting swp (E), 4001 must pick 0
    cycle(16'h4000, 1'b1, 1'b0);
    check("wrap_swp", {28'd0, op_sel}, 32'hE);
    cycle(16'h0000, 1'b1, 1'b0);
    cycle(16'h4001, 1'b0, 1'b0);
    check("wrap_sel", {28'd0, op_sel}, 32'h0);
    cycle(16'h0000, 1'b1, 1'b0);

    // Reset during an accepted offer
    cycle(16'h0030, 1'b0, 1'b0);
    check("rmo_offer", {31'd0, op_valid}, 32'd1);
    cycle(16'h0030, 1'b1, 1'b1);
    check("rmo_valid", {31'd0, op_valid}, 32'd0);
    check("rmo_cnt",   {24'd0, issue_cnt},32'd0);
    cycle(16'h0030, 1'b1, 1'b0);
    check("rmo_first", {28'd0, op_sel},   32'd4);

    // 256 accepted handshakes wrap the counter
    cycle(16'h0000, 1'b0, 1'b1);
    cycle(16'h0001, 1'b1, 1'b0);
    for (int i = 1; i <= 256; i++) begin
      cycle(16'h0001, 1'b1, 1'b0);
      if (i == 255) check("cnt_255", {24'd0, issue_cnt}, 32'd255);
    end
    check("cnt_wrap",       {24'd0, issue_cnt}, 32'd0);
    check("cnt_wrap_valid", {31'd0, op_valid},  32'd1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom() & $urandom());
      cycle(r, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end
    cycle(16'h0000, 1'b1, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
